// File: rtl/arb_pkg.sv
// Shared definitions for the N-way grant arbiter: one-hot FSM encoding and index-width helper.
package arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_GNT  = 3'b010,
        ST_REL  = 3'b100
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n_rr_pick.sv
// Combinational winner select: first set request at or above ptr, wrapping; ptr ignored when rr_en=0.
// Zero latency, pure logic; no flow control of its own.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]               req,
    input  logic [clog2_min1(N)-1:0]   ptr,
    input  logic                       rr_en,
    output logic [clog2_min1(N)-1:0]   win_id,
    output logic                       win_valid
);

    localparam int IW = clog2_min1(N);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;

    // Lower half keeps only requests at/above ptr; upper half supplies the wrap-around.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (!rr_en || (i >= int'(ptr)));
        end
        dbl    = {req, masked};
        win_id = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                win_id = IW'(i % N);
            end
        end
    end

    assign win_valid = |req;

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with registered one-hot grant, hold-until-release and optional hold timeout.
// One cycle req->gnt; one mandatory bubble between owners; non-owner requests wait (no preemption).
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    parameter bit RR       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req,
    output logic [N-1:0]               gnt,
    output logic                       gnt_valid,
    output logic [clog2_min1(N)-1:0]   gnt_id,
    output logic                       timeout
);

    localparam int IW = clog2_min1(N);
    localparam int CW = clog2_min1(HOLD_MAX + 1);
    // With no hold limit the counter just saturates at all-ones.
    localparam logic [CW-1:0] CNT_MAX = (HOLD_MAX == 0) ? {CW{1'b1}} : CW'(HOLD_MAX);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   win_id;
    logic            win_valid;
    logic            owner_req;
    logic            hold_ok;

    rr_pick #(.N(N)) u_pick (
        .req       (req),
        .ptr       (ptr),
        .rr_en     (RR),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    assign owner_req = req[gnt_id];
    assign hold_ok   = (HOLD_MAX == 0) || (cnt < CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_GNT: begin
                    if (owner_req && hold_ok) begin
                        if (cnt != {CW{1'b1}}) begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state     <= ST_REL;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                        cnt       <= '0;
                        timeout   <= owner_req;
                    end
                end
                default: begin
                    // IDLE and the REL bubble both arbitrate on the current request vector.
                    if (win_valid) begin
                        state     <= ST_GNT;
                        gnt       <= N'(1) << win_id;
                        gnt_valid <= 1'b1;
                        gnt_id    <= win_id;
                        cnt       <= CW'(1);
                        ptr       <= (win_id == IW'(N - 1)) ? '0 : win_id + IW'(1);
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: three instances (RR/HOLD_MAX=2, RR/unlimited, fixed priority).
module tb_rr_arbiter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = 4'b0000, req_b = 4'b0000, req_c = 4'b0000;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic       gv_a, gv_b, gv_c;
    logic [1:0] id_a, id_b, id_c;
    logic       to_a, to_b, to_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [3:0] g;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .HOLD_MAX(2), .RR(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a), .timeout(to_a)
    );
    rr_arbiter_n #(.N(4), .HOLD_MAX(0), .RR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b), .timeout(to_b)
    );
    rr_arbiter_n #(.N(4), .HOLD_MAX(16), .RR(1'b0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_valid(gv_c), .gnt_id(id_c), .timeout(to_c)
    );

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic expect_out(input int sel, input logic [3:0] g, input logic to, input string tag);
        exp_t e;
        e.sel = sel;
        e.g   = g;
        e.to  = to;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every queued expectation against the outputs.
    task automatic cyc();
        exp_t       e;
        logic [3:0] ag;
        logic       av;
        logic [1:0] ai;
        logic       ato;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       begin ag = gnt_a; av = gv_a; ai = id_a; ato = to_a; end
                1:       begin ag = gnt_b; av = gv_b; ai = id_b; ato = to_b; end
                default: begin ag = gnt_c; av = gv_c; ai = id_c; ato = to_c; end
            endcase
            checks++;
            assert ({ag, av, ai, ato} === {e.g, |e.g, idx_of(e.g), e.to})
            else begin
                errors++;
                $error("FAIL %s: observed gnt=%b vld=%b id=%0d to=%b, expected gnt=%b vld=%b id=%0d to=%b",
                       e.tag, ag, av, ai, ato, e.g, |e.g, idx_of(e.g), e.to);
            end
        end
    endtask

    initial begin
        // T1: reset held with all requests asserted
        req_a = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            expect_out(0, 4'b0000, 1'b0, "t1_reset_a");
            expect_out(1, 4'b0000, 1'b0, "t1_reset_b");
            expect_out(2, 4'b0000, 1'b0, "t1_reset_c");
            cyc();
        end
        rst = 1'b0;
        expect_out(0, 4'b0001, 1'b0, "t1_first_grant");
        cyc();

        // T2: round-robin rotation, HOLD_MAX=2
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                expect_out(0, 4'(1 << (k % 4)), 1'b0, "t2_grant_c1");
                cyc();
            end
            expect_out(0, 4'(1 << (k % 4)), 1'b0, "t2_grant_c2");
            cyc();
            expect_out(0, 4'b0000, 1'b1, "t2_timeout");
            cyc();
        end
        req_a = 4'b0000;
        expect_out(0, 4'b0000, 1'b0, "t2_idle");
        cyc();

        // T3: voluntary release, unlimited hold
        req_b = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            expect_out(1, 4'b0100, 1'b0, "t3_held");
            cyc();
        end
        req_b = 4'b0000;
        expect_out(1, 4'b0000, 1'b0, "t3_release");
        cyc();
        expect_out(1, 4'b0000, 1'b0, "t3_idle");
        cyc();

        // T4: no preemption of owner 3 by requester 0
        req_b = 4'b1000;
        expect_out(1, 4'b1000, 1'b0, "t4_grant3");
        cyc();
        req_b = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 4'b1000, 1'b0, "t4_no_preempt");
            cyc();
        end
        req_b = 4'b0001;
        expect_out(1, 4'b0000, 1'b0, "t4_bubble");
        cyc();
        expect_out(1, 4'b0001, 1'b0, "t4_grant0");
        cyc();

        // T5: fixed priority keeps choosing requester 1 over 3
        req_c = 4'b1010;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                expect_out(2, 4'b0010, 1'b0, "t5_fixed_grant");
                cyc();
            end
            req_c = 4'b1000;
            expect_out(2, 4'b0000, 1'b0, "t5_bubble");
            cyc();
            req_c = 4'b1010;
        end
        expect_out(2, 4'b0010, 1'b0, "t5_final_grant");
        cyc();

        // T6: long hold without timeout, then reset mid-grant
        for (int i = 0; i < 100; i++) begin
            expect_out(1, 4'b0001, 1'b0, "t6_long_hold");
            cyc();
        end
        rst = 1'b1;
        expect_out(1, 4'b0000, 1'b0, "t6_rst_drop");
        expect_out(2, 4'b0000, 1'b0, "t6_rst_drop_c");
        cyc();
        rst = 1'b0;
        req_b = 4'b1111;
        expect_out(1, 4'b0001, 1'b0, "t6_ptr_reset");
        cyc();
        expect_out(1, 4'b0001, 1'b0, "t6_hold_after_rst");
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
